reg_pipe: RTL

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit registers, each with a valid bit, joined by a valid/ready handshake. It is the next generation of the single-bit async-reset D flip-flop. It adds width, depth, back-pressure stall, synchronous flush and occupancy reporting. Used wherever a datapath needs N cycles of registered delay that can stall without losing data.

---
 rtl/reg_pipe_pkg.sv | 16 +
 rtl/reg_pipe_stage.sv | 32 +++
 rtl/reg_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/reg_pipe_pkg.sv
// rtl/reg_pipe_pkg.sv - shared constants and helpers for the elastic register pipeline
package reg_pipe_pkg;

    localparam int REG_PIPE_MAX_DEPTH = 16;

    // Bits needed to count 0..depth inclusive.
    function automatic int clog2_plus1(input int depth);
        int n;
        n = 0;
        for (int v = depth; v > 0; v = v >> 1) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one pipeline register with valid bit, load enable and flush
module reg_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= up_valid;
            end
            // Data only moves with a real word so bubbles cause no toggling.
            if (load && up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - elastic DEPTH-stage register pipeline; optional parity via REG_PIPE_PARITY_EN
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = clog2_plus1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy,
    output logic             out_perr
);

`ifdef REG_PIPE_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [DEPTH-1:0] vld;
    logic [SW-1:0]    word [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [SW-1:0]    in_word;
    logic             in_xfer;
    logic             out_xfer;

`ifdef REG_PIPE_PARITY_EN
    // Parity rides in the top bit of each stage word.
    assign in_word  = {^in_data, in_data};
    assign out_perr = vld[DEPTH-1] & ((^word[DEPTH-1][WIDTH-1:0]) != word[DEPTH-1][WIDTH]);
`else
    assign in_word  = in_data;
    assign out_perr = 1'b0;
`endif

    // A stage can load if it is empty or its downstream neighbour can load.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] | rdy[k+1];
        end
    end

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_first
                reg_pipe_stage #(.W(SW)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .flush    (flush),
                    .load     (rdy[0]),
                    .up_valid (in_valid),
                    .up_data  (in_word),
                    .valid    (vld[0]),
                    .data     (word[0])
                );
            end else begin : g_next
                reg_pipe_stage #(.W(SW)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .flush    (flush),
                    .load     (rdy[k]),
                    .up_valid (vld[k-1]),
                    .up_data  (word[k-1]),
                    .valid    (vld[k]),
                    .data     (word[k])
                );
            end
        end
    endgenerate

    assign in_ready  = rdy[0];
    assign out_valid = vld[DEPTH-1];
    assign out_data  = word[DEPTH-1][WIDTH-1:0];
    assign in_xfer   = in_valid & rdy[0];
    assign out_xfer  = vld[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule
